// File: rtl/some_submodule_unit.sv
// some_submodule_unit: nibble packer. 4-bit samples on c are collected
// little-endian into W_DATA-wide words. A word is emitted when it is full,
// or earlier as a partial word when b requests a flush.
// Optional feature macro: SOME_SUBMODULE_PARITY_EN adds the o_parity output,
// which is the XOR reduction of the emitted word.
module some_submodule_unit #(
  parameter int W_DATA = 32,
  parameter int W_CNT  = $clog2(W_DATA/4)+1
) (
  input  logic              a,
  input  logic              b,
  input  logic [3:0]        c,
  input  logic              i_clk,
  input  logic              reset,
  output logic [W_DATA-1:0] o_word,
  output logic              o_valid,
  output logic [W_CNT-1:0]  o_count,
  output logic              o_busy
`ifdef SOME_SUBMODULE_PARITY_EN
  ,
  output logic              o_parity
`endif
);

  localparam int N = W_DATA/4;
  localparam logic [W_CNT-1:0] LAST_SLOT = W_CNT'(N-1);

  logic [W_DATA-1:0] buffer;
  logic [W_CNT-1:0]  idx;
  logic [W_DATA-1:0] merged;
  logic              emit;
  logic [W_DATA-1:0] emit_word;
  logic [W_CNT-1:0]  emit_count;

  // Merge the incoming nibble into its slot and decide whether this cycle emits a word
  always_comb begin
    merged     = buffer;
    emit       = 1'b0;
    emit_word  = buffer;
    emit_count = idx;
    for (int k = 0; k < N; k++) begin
      if (idx == W_CNT'(k)) begin
        merged[4*k +: 4] = c;
      end
    end
    if (a) begin
      emit       = b || (idx == LAST_SLOT);
      emit_word  = merged;
      emit_count = idx + W_CNT'(1);
    end else if (b && (idx != '0)) begin
      emit       = 1'b1;
      emit_word  = buffer;
      emit_count = idx;
    end
  end

  // Slot index, packing buffer and registered word outputs; reset discards any pending nibbles
  always_ff @(posedge i_clk) begin
    if (reset) begin
      buffer  <= '0;
      idx     <= '0;
      o_word  <= '0;
      o_valid <= 1'b0;
      o_count <= '0;
    end else begin
      o_valid <= emit;
      if (emit) begin
        o_word  <= emit_word;
        o_count <= emit_count;
        buffer  <= '0;
        idx     <= '0;
      end else if (a) begin
        buffer  <= merged;
        idx     <= idx + W_CNT'(1);
      end
    end
  end

`ifdef SOME_SUBMODULE_PARITY_EN
  // Parity of the emitted word, updated only when o_word itself is updated
  always_ff @(posedge i_clk) begin
    if (reset) begin
      o_parity <= 1'b0;
    end else if (emit) begin
      o_parity <= ^emit_word;
    end
  end
`endif

  assign o_busy = (idx != '0);

endmodule

// File: tb/tb_some_submodule_unit.sv
// tb_some_submodule_unit: self-checking bench for some_submodule_unit with
// W_DATA=32. Directed scenarios plus a randomized run, compared each cycle
// against a queue-based reference model of the packer.
// Parity checks are active when SOME_SUBMODULE_PARITY_EN is defined.
module tb_some_submodule_unit;

  localparam int W     = 32;
  localparam int N     = W/4;
  localparam int W_CNT = $clog2(N)+1;

  logic          i_clk;
  logic          reset;
  logic          a;
  logic          b;
  logic [3:0]    c;
  logic [W-1:0]  o_word;
  logic          o_valid;
  logic [W_CNT-1:0] o_count;
  logic          o_busy;
`ifdef SOME_SUBMODULE_PARITY_EN
  logic          o_parity;
`endif

  int checks;
  int failures;

  // Reference model state: pending nibbles in arrival order plus last emission
  int unsigned   pending[$];
  logic [W-1:0]  m_word;
  logic          m_valid;
  int            m_count;
  logic          m_parity;

  some_submodule_unit #(.W_DATA(W)) dut (
    .a(a),
    .b(b),
    .c(c),
    .i_clk(i_clk),
    .reset(reset),
    .o_word(o_word),
    .o_valid(o_valid),
    .o_count(o_count),
    .o_busy(o_busy)
`ifdef SOME_SUBMODULE_PARITY_EN
    ,
    .o_parity(o_parity)
`endif
  );

  // Free-running clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Apply the rules of the packer to the inputs seen at this clock edge
  task automatic modelStep(input logic ra, input logic rb, input logic [3:0] rc,
                           input logic rr);
    logic do_emit;
    logic [W-1:0] nib;
    m_valid = 1'b0;
    if (rr) begin
      pending.delete();
      m_word   = '0;
      m_count  = 0;
      m_parity = 1'b0;
    end else begin
      if (ra) pending.push_back(int'(rc));
      do_emit = (ra && (rb || pending.size() == N)) ||
                (!ra && rb && pending.size() > 0);
      if (do_emit) begin
        m_word = '0;
        foreach (pending[k]) begin
          nib = W'(pending[k]);
          m_word = m_word | (nib << (4*k));
        end
        m_count  = pending.size();
        m_parity = ^m_word;
        m_valid  = 1'b1;
        pending.delete();
      end
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic rb, input logic [3:0] rc,
                               input logic rr);
    a     = ra;
    b     = rb;
    c     = rc;
    reset = rr;
    @(posedge i_clk);
    modelStep(ra, rb, rc, rr);
    #1;
    checkOutput("valid", 64'(o_valid), 64'(m_valid));
    checkOutput("word",  64'(o_word),  64'(m_word));
    checkOutput("count", 64'(o_count), 64'(m_count));
    checkOutput("busy",  64'(o_busy),  64'(pending.size() != 0));
`ifdef SOME_SUBMODULE_PARITY_EN
    checkOutput("parity", 64'(o_parity), 64'(m_parity));
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_word   = '0;
    m_valid  = 1'b0;
    m_count  = 0;
    m_parity = 1'b0;
    a = 1'b0; b = 1'b0; c = 4'h0; reset = 1'b1;

    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'hF, 1'b1);
    checkOutput("rst_word",  64'(o_word), 64'h0);
    checkOutput("rst_valid", 64'(o_valid), 64'h0);
    checkOutput("rst_count", 64'(o_count), 64'h0);
    checkOutput("rst_busy",  64'(o_busy), 64'h0);

    // Full word 1..8
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 4'(i), 1'b0);
    checkOutput("full_valid", 64'(o_valid), 64'h1);
    checkOutput("full_word",  64'(o_word), 64'h87654321);
    checkOutput("full_count", 64'(o_count), 64'd8);
    checkOutput("full_busy",  64'(o_busy), 64'h0);

    // Partial flush, then an empty flush
    applyStimulus(1'b1, 1'b0, 4'hA, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'hB, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'hC, 1'b0);
    checkOutput("part_busy", 64'(o_busy), 64'h1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
    checkOutput("part_valid", 64'(o_valid), 64'h1);
    checkOutput("part_word",  64'(o_word), 64'h00000CBA);
    checkOutput("part_count", 64'(o_count), 64'd3);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
    checkOutput("empty_flush_valid", 64'(o_valid), 64'h0);
    checkOutput("hold_word", 64'(o_word), 64'h00000CBA);

    // Flush together with data
    applyStimulus(1'b1, 1'b0, 4'h5, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h6, 1'b0);
    checkOutput("flushdata_valid", 64'(o_valid), 64'h1);
    checkOutput("flushdata_word",  64'(o_word), 64'h00000065);
    checkOutput("flushdata_count", 64'(o_count), 64'd2);
    checkOutput("flushdata_busy",  64'(o_busy), 64'h0);

    // Reset mid-word discards pending nibbles
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 4'(i + 3), 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
    checkOutput("rst_flush_valid", 64'(o_valid), 64'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 4'hF, 1'b0);
    checkOutput("ones_word",  64'(o_word), 64'hFFFFFFFF);
    checkOutput("ones_count", 64'(o_count), 64'd8);

    // Sixteen consecutive nibbles, two back-to-back words
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 4'(i), 1'b0);
      if (i == 7) checkOutput("seq_word0", 64'(o_word), 64'h76543210);
      if (i == 8) begin
        checkOutput("seq_hold_word", 64'(o_word), 64'h76543210);
        checkOutput("seq_hold_valid", 64'(o_valid), 64'h0);
      end
      if (i == 15) checkOutput("seq_word1", 64'(o_word), 64'hFEDCBA98);
    end

`ifdef SOME_SUBMODULE_PARITY_EN
    applyStimulus(1'b1, 1'b1, 4'h1, 1'b0);
    checkOutput("parity_one", 64'(o_parity), 64'h1);
    applyStimulus(1'b1, 1'b1, 4'h3, 1'b0);
    checkOutput("parity_three", 64'(o_parity), 64'h0);
`endif

    // Randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/some_submodule_unit.md
Name: some_submodule_unit

Overview:
- Nibble packer. Collects 4-bit samples on c into W_DATA-wide words and emits one word per W_DATA/4 accepted nibbles, or a partial word on flush.
- Instantiated as a leaf under the pipe_pal datapath.
- Connection order: a (sample strobe), b (flush), c (nibble), then the added clock/reset/output ports.

Parameters:
- W_DATA, 32, output word width in bits. Must be a multiple of 4 and >= 8.
- W_CNT, $clog2(W_DATA/4)+1, width of the nibble count. Derived; do not override.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  1  sample strobe; c is accepted this cycle when a=1.
- b  input  1  flush request; emit the pending partial word.
- c  input  4  nibble data.
- o_word  output  W_DATA  packed word; nibble k at bits [4k+3:4k].
- o_valid  output  1  one-cycle pulse; o_word and o_count are new this cycle.
- o_count  output  W_CNT  number of valid nibbles in o_word (1..W_DATA/4).
- o_busy  output  1  1 when a partial word is pending (slot index != 0).

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset state: o_word=0, o_valid=0, o_count=0, o_busy=0, internal slot index=0, internal buffer=0.
- Reset is dominant: when reset=1, a, b and c are ignored that cycle. Reset mid-word discards the pending nibbles and emits nothing.
- Packing is little-endian. The first accepted nibble after an emission lands in bits [3:0]; the next in [7:4]; and so on.
- Let N = W_DATA/4 and idx = the current slot index.
- a=1, b=0, idx<N-1: write c into slot idx, idx<=idx+1, no emission.
- a=1, b=0, idx=N-1: emit the full word including this c. Next cycle: o_valid=1, o_count=N, o_word=buffer with c in the top slot. idx<=0 and the buffer is cleared.
- b=1 and a=1 (any idx): c is included, then emit immediately with o_count=idx+1. When idx=N-1 this is identical to a full-word emission.
- b=1, a=0, idx>0: emit the partial word with o_count=idx. Unfilled upper slots read 0. idx<=0.
- b=1, a=0, idx=0: no-op, no emission.
- a=0, b=0: hold state.
- Latency: exactly 1 cycle from the accepting/flush edge to the o_valid pulse. Back-to-back emissions on consecutive cycles are legal.
- o_valid is high for exactly one cycle per emission.
- o_word and o_count hold their last emitted values until the next emission. They are not cleared when o_valid drops.
- o_busy reflects the registered idx != 0. It is 0 in the same cycle that o_valid pulses for a full word.
- No backpressure: the consumer must accept every o_valid pulse.

Optional Feature:
- Macro: SOME_SUBMODULE_PARITY_EN.
- Defined: adds output port o_parity (1 bit).
  - o_parity = XOR reduction of the emitted o_word, registered alongside o_word.
  - Reset value 0; holds with o_word between emissions.
- Undefined: the o_parity port and its logic are absent. All other behaviour is identical.

Test Plan (W_DATA=32, N=8):
- Reset, then 8 cycles of a=1 with c=1,2,...,8 -> one cycle after the 8th: o_valid=1, o_word=32'h87654321, o_count=8, o_busy=0.
- a=1 with c=A,B,C, then one cycle b=1, a=0 -> o_valid=1, o_word=32'h00000CBA, o_count=3. A second b=1 with no data -> no pulse.
- a=1, c=5, then a=1, b=1, c=6 in the same cycle -> o_valid=1, o_word=32'h00000065, o_count=2, o_busy=0.
- Feed 5 nibbles, assert reset for 1 cycle, then flush -> no o_valid. Then 8 nibbles of F -> o_word=32'hFFFFFFFF, o_count=8.
- 16 consecutive a=1 cycles, c=0..F -> pulses 1 cycle after the 8th and 16th nibble: 32'h76543210, then 32'hFEDCBA98. Outputs hold between pulses.
- With SOME_SUBMODULE_PARITY_EN defined, emit 32'h00000001 -> o_parity=1; emit 32'h00000003 -> o_parity=0.
